// File: rtl/victim_cache_ctrl.sv
// Victim cache controller: fully associative tag/valid/dirty store sitting behind the dcache.
// Handles miss lookups, eviction inserts with writeback of displaced dirty lines, and flush.
module victim_cache_ctrl #(
  parameter int unsigned VC_ENTRIES = 4,
  parameter int unsigned TAG_BITS   = 26,
  localparam int unsigned IDX_W     = $clog2(VC_ENTRIES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lookup_req_i,
  input  logic [TAG_BITS-1:0] lookup_tag_i,
  input  logic                lookup_take_i,
  output logic                lookup_valid_o,
  output logic                lookup_hit_o,
  output logic [IDX_W-1:0]    lookup_idx_o,
  output logic                lookup_dirty_o,
  input  logic                insert_req_i,
  input  logic [TAG_BITS-1:0] insert_tag_i,
  input  logic                insert_dirty_i,
  output logic                insert_ack_o,
  output logic                vc_data_wr_o,
  output logic [IDX_W-1:0]    vc_data_idx_o,
  output logic                vc2mem_req_o,
  output logic                vc2mem_wr_o,
  input  logic                mem2vc_ack_i,
  output logic                vc2mem_kill_o,
  input  logic                flush_i,
  output logic                flush_done_o,
  input  logic                kill_i,
  output logic                busy_o,
  output logic [IDX_W:0]      occupancy_o
);

  typedef enum logic [2:0] {
    StIdle, StWb, StInsert, StFlushScan, StFlushWb, StFlushDone
  } state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(VC_ENTRIES - 1);

  state_e                state_q, state_d;
  logic [VC_ENTRIES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_BITS-1:0]   tag_q [VC_ENTRIES];
  logic [IDX_W-1:0]      rr_q, rr_d, scan_q, scan_d, tgt_q, tgt_d;
  logic                  dup_q, dup_d;
  logic [TAG_BITS-1:0]   ins_tag_q, ins_tag_d;
  logic                  ins_dirty_q, ins_dirty_d;
  logic                  lk_valid_q, lk_valid_d, lk_hit_q, lk_hit_d, lk_dirty_q, lk_dirty_d;
  logic [IDX_W-1:0]      lk_idx_q, lk_idx_d;
  logic                  tag_we, scan_end;

  logic [VC_ENTRIES-1:0] lk_match, ins_match;
  logic [IDX_W-1:0]      lk_sel, ins_sel, free_sel;
  logic [IDX_W:0]        occ;

  // Associative compare and lowest-index priority encoders.
  always_comb begin
    lk_match  = '0;
    ins_match = '0;
    lk_sel    = '0;
    ins_sel   = '0;
    free_sel  = '0;
    occ       = '0;
    for (int i = 0; i < VC_ENTRIES; i++) begin
      lk_match[i]  = valid_q[i] && (tag_q[i] == lookup_tag_i);
      ins_match[i] = valid_q[i] && (tag_q[i] == insert_tag_i);
      occ          = occ + (IDX_W+1)'(valid_q[i]);
    end
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      if (lk_match[i])  lk_sel   = IDX_W'(i);
      if (ins_match[i]) ins_sel  = IDX_W'(i);
      if (!valid_q[i])  free_sel = IDX_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    rr_d        = rr_q;
    scan_d      = scan_q;
    tgt_d       = tgt_q;
    dup_d       = dup_q;
    ins_tag_d   = ins_tag_q;
    ins_dirty_d = ins_dirty_q;
    lk_valid_d  = 1'b0;
    lk_hit_d    = 1'b0;
    lk_idx_d    = '0;
    lk_dirty_d  = 1'b0;
    tag_we      = 1'b0;
    scan_end    = 1'b0;
    if (kill_i) begin
      state_d = StIdle;
      scan_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_i) begin
            state_d = StFlushScan;
            scan_d  = '0;
          end else if (insert_req_i) begin
            ins_tag_d   = insert_tag_i;
            ins_dirty_d = insert_dirty_i;
            state_d     = StInsert;
            if (|ins_match) begin
              tgt_d = ins_sel;
              dup_d = 1'b1;
            end else if (!(&valid_q)) begin
              tgt_d = free_sel;
              dup_d = 1'b0;
            end else begin
              // Buffer full: displace the round-robin victim, writing it back if dirty.
              tgt_d = rr_q;
              dup_d = 1'b0;
              rr_d  = rr_q + 1'b1;
              if (dirty_q[rr_q]) state_d = StWb;
            end
          end else if (lookup_req_i) begin
            lk_valid_d = 1'b1;
            lk_hit_d   = |lk_match;
            lk_idx_d   = lk_hit_d ? lk_sel : '0;
            lk_dirty_d = lk_hit_d && dirty_q[lk_sel];
            if (lk_hit_d && lookup_take_i) begin
              valid_d[lk_sel] = 1'b0;
              dirty_d[lk_sel] = 1'b0;
            end
          end
        end
        StWb: if (mem2vc_ack_i) state_d = StInsert;
        StInsert: begin
          valid_d[tgt_q] = 1'b1;
          dirty_d[tgt_q] = ins_dirty_q | (dup_q & dirty_q[tgt_q]);
          tag_we         = 1'b1;
          state_d        = StIdle;
        end
        StFlushScan: begin
          if (valid_q[scan_q] && dirty_q[scan_q]) state_d = StFlushWb;
          else if (scan_q == LastIdx)             scan_end = 1'b1;
          else                                    scan_d = scan_q + 1'b1;
        end
        StFlushWb: begin
          if (mem2vc_ack_i) begin
            dirty_d[scan_q] = 1'b0;
            if (scan_q == LastIdx) begin
              scan_end = 1'b1;
            end else begin
              scan_d  = scan_q + 1'b1;
              state_d = StFlushScan;
            end
          end
        end
        StFlushDone: state_d = StIdle;
        default:     state_d = StIdle;
      endcase
      if (scan_end) begin
        valid_d = '0;
        dirty_d = '0;
        rr_d    = '0;
        scan_d  = '0;
        state_d = StFlushDone;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      rr_q        <= '0;
      scan_q      <= '0;
      tgt_q       <= '0;
      dup_q       <= 1'b0;
      ins_tag_q   <= '0;
      ins_dirty_q <= 1'b0;
      lk_valid_q  <= 1'b0;
      lk_hit_q    <= 1'b0;
      lk_idx_q    <= '0;
      lk_dirty_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      rr_q        <= rr_d;
      scan_q      <= scan_d;
      tgt_q       <= tgt_d;
      dup_q       <= dup_d;
      ins_tag_q   <= ins_tag_d;
      ins_dirty_q <= ins_dirty_d;
      lk_valid_q  <= lk_valid_d;
      lk_hit_q    <= lk_hit_d;
      lk_idx_q    <= lk_idx_d;
      lk_dirty_q  <= lk_dirty_d;
    end
  end

  // Tags are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rst_n && tag_we) tag_q[tgt_q] <= ins_tag_q;
  end

  assign lookup_valid_o = lk_valid_q;
  assign lookup_hit_o   = lk_hit_q;
  assign lookup_idx_o   = lk_idx_q;
  assign lookup_dirty_o = lk_dirty_q;
  assign vc2mem_req_o   = ((state_q == StWb) || (state_q == StFlushWb)) && !kill_i;
  assign vc2mem_wr_o    = vc2mem_req_o;
  assign vc2mem_kill_o  = kill_i;
  assign vc_data_wr_o   = (state_q == StInsert) && !kill_i;
  assign insert_ack_o   = vc_data_wr_o;
  assign vc_data_idx_o  = (state_q == StFlushWb) ? scan_q :
                          ((state_q == StWb) || (state_q == StInsert)) ? tgt_q : '0;
  assign flush_done_o   = (state_q == StFlushDone);
  assign busy_o         = (state_q != StIdle);
  assign occupancy_o    = occ;

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Scoreboard bench for victim_cache_ctrl: expected responses are queued when a request is
// driven and retired by a negedge monitor as the DUT produces lookup, insert and writeback events.
module tb_victim_cache_ctrl;

  localparam int unsigned Entries = 4;
  localparam int unsigned TagBits = 26;
  localparam int unsigned IdxW    = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               lookup_req_i = 1'b0, lookup_take_i = 1'b0;
  logic [TagBits-1:0] lookup_tag_i = '0;
  logic               lookup_valid_o, lookup_hit_o, lookup_dirty_o;
  logic [IdxW-1:0]    lookup_idx_o;
  logic               insert_req_i = 1'b0, insert_dirty_i = 1'b0;
  logic [TagBits-1:0] insert_tag_i = '0;
  logic               insert_ack_o, vc_data_wr_o;
  logic [IdxW-1:0]    vc_data_idx_o;
  logic               vc2mem_req_o, vc2mem_wr_o, vc2mem_kill_o;
  logic               mem2vc_ack_i = 1'b0, flush_i = 1'b0, kill_i = 1'b0;
  logic               flush_done_o, busy_o;
  logic [IdxW:0]      occupancy_o;

  victim_cache_ctrl #(.VC_ENTRIES(Entries), .TAG_BITS(TagBits)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lookup_req_i   (lookup_req_i),
    .lookup_tag_i   (lookup_tag_i),
    .lookup_take_i  (lookup_take_i),
    .lookup_valid_o (lookup_valid_o),
    .lookup_hit_o   (lookup_hit_o),
    .lookup_idx_o   (lookup_idx_o),
    .lookup_dirty_o (lookup_dirty_o),
    .insert_req_i   (insert_req_i),
    .insert_tag_i   (insert_tag_i),
    .insert_dirty_i (insert_dirty_i),
    .insert_ack_o   (insert_ack_o),
    .vc_data_wr_o   (vc_data_wr_o),
    .vc_data_idx_o  (vc_data_idx_o),
    .vc2mem_req_o   (vc2mem_req_o),
    .vc2mem_wr_o    (vc2mem_wr_o),
    .mem2vc_ack_i   (mem2vc_ack_i),
    .vc2mem_kill_o  (vc2mem_kill_o),
    .flush_i        (flush_i),
    .flush_done_o   (flush_done_o),
    .kill_i         (kill_i),
    .busy_o         (busy_o),
    .occupancy_o    (occupancy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            hit;
    logic [IdxW-1:0] idx;
    logic            dirty;
  } lk_exp_t;

  lk_exp_t lq[$];
  int      iq[$];
  int      wq[$];
  lk_exp_t mon_e;
  int      mon_i;
  logic    wb_prev = 1'b0;
  int      errors = 0;
  int      checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor retires scoreboard entries as the DUT emits events.
  always @(negedge clk) begin
    if (lookup_valid_o) begin
      check("lk_sb_pending", lq.size(), 1);
      if (lq.size() > 0) begin
        mon_e = lq.pop_front();
        check("lk_hit", lookup_hit_o, mon_e.hit);
        check("lk_idx", lookup_idx_o, mon_e.idx);
        check("lk_dirty", lookup_dirty_o, mon_e.dirty);
      end
    end
    if (insert_ack_o) begin
      check("ins_sb_pending", iq.size(), 1);
      check("ins_data_wr", vc_data_wr_o, 1);
      if (iq.size() > 0) begin
        mon_i = iq.pop_front();
        check("ins_idx", vc_data_idx_o, mon_i);
      end
    end
    if (vc2mem_req_o && !wb_prev) begin
      check("wb_sb_pending", (wq.size() > 0) ? 1 : 0, 1);
      check("wb_wr", vc2mem_wr_o, 1);
      if (wq.size() > 0) begin
        mon_i = wq.pop_front();
        check("wb_idx", vc_data_idx_o, mon_i);
      end
    end
    wb_prev <= vc2mem_req_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [TagBits-1:0] tag, input logic take,
                           input logic hit, input int idx, input logic dirty);
    lq.push_back('{hit: hit, idx: IdxW'(idx), dirty: dirty});
    lookup_req_i  = 1'b1;
    lookup_tag_i  = tag;
    lookup_take_i = take;
    step();
    lookup_req_i  = 1'b0;
    lookup_take_i = 1'b0;
    @(negedge clk);
    check("lk_latency", lookup_valid_o, 1);
    step();
  endtask

  task automatic do_insert(input logic [TagBits-1:0] tag, input logic dirty,
                           input int idx, input logic wb, input int delay);
    iq.push_back(idx);
    if (wb) wq.push_back(idx);
    insert_req_i   = 1'b1;
    insert_tag_i   = tag;
    insert_dirty_i = dirty;
    step();
    insert_req_i   = 1'b0;
    if (wb) begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        check("wb_hold", {vc2mem_req_o, vc2mem_wr_o, insert_ack_o}, 3'b110);
        step();
      end
      mem2vc_ack_i = 1'b1;
      step();
      mem2vc_ack_i = 1'b0;
    end
    @(negedge clk);
    check("ins_latency", insert_ack_o, 1);
    step();
  endtask

  task automatic do_flush(input logic with_ins, input int exp_cycles);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    flush_i      = 1'b1;
    insert_req_i = with_ins;
    insert_tag_i = 26'h55;
    step();
    flush_i      = 1'b0;
    insert_req_i = 1'b0;
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
      if (flush_done_o) done = 1'b1;
      else mem2vc_ack_i = vc2mem_req_o;
      step();
      mem2vc_ack_i = 1'b0;
    end
    check("fl_done", done, 1);
    if (exp_cycles > 0) check("fl_cycles", n, exp_cycles);
    @(negedge clk);
    check("fl_single_pulse", flush_done_o, 0);
    check("fl_occ", occupancy_o, 0);
    check("fl_idle", busy_o, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    @(negedge clk);
    check("rst_outputs", {busy_o, lookup_valid_o, insert_ack_o, vc2mem_req_o, flush_done_o,
                          vc_data_wr_o}, 6'b0);
    check("rst_occ", occupancy_o, 0);
    step();
    rst_n = 1'b1;
    step();

    do_lookup(26'h123, 1'b0, 1'b0, 0, 1'b0);
    check("occ_empty", occupancy_o, 0);

    do_insert(26'hA, 1'b0, 0, 1'b0, 0);
    do_insert(26'hB, 1'b0, 1, 1'b0, 0);
    do_insert(26'hC, 1'b0, 2, 1'b0, 0);
    do_insert(26'hD, 1'b0, 3, 1'b0, 0);
    check("occ_full", occupancy_o, 4);

    do_lookup(26'hC, 1'b1, 1'b1, 2, 1'b0);
    check("occ_after_take", occupancy_o, 3);

    // Dirty duplicate of A stays at idx 0; refill the freed slot 2.
    do_insert(26'hA, 1'b1, 0, 1'b0, 0);
    check("occ_dup", occupancy_o, 3);
    do_insert(26'hC, 1'b0, 2, 1'b0, 0);
    check("occ_refill", occupancy_o, 4);

    // Full with entry 0 dirty: round-robin victim 0 is written back first.
    do_insert(26'hE, 1'b0, 0, 1'b1, 3);
    do_lookup(26'hA, 1'b0, 1'b0, 0, 1'b0);
    do_lookup(26'hE, 1'b0, 1'b1, 0, 1'b0);

    do_insert(26'hB, 1'b1, 1, 1'b0, 0);
    check("occ_dup_b", occupancy_o, 4);
    do_lookup(26'hB, 1'b0, 1'b1, 1, 1'b1);

    // Next victim is rr=1 (dirty B): kill the writeback mid-flight.
    wq.push_back(1);
    insert_req_i   = 1'b1;
    insert_tag_i   = 26'hF;
    insert_dirty_i = 1'b0;
    step();
    insert_req_i = 1'b0;
    @(negedge clk);
    check("kill_pre_req", vc2mem_req_o, 1);
    step();
    kill_i = 1'b1;
    @(negedge clk);
    check("kill_o", vc2mem_kill_o, 1);
    check("kill_req_drop", {vc2mem_req_o, insert_ack_o, vc_data_wr_o}, 3'b000);
    step();
    kill_i = 1'b0;
    @(negedge clk);
    check("kill_idle", busy_o, 0);
    check("kill_occ", occupancy_o, 4);
    step();
    do_lookup(26'hB, 1'b0, 1'b1, 1, 1'b1);
    do_lookup(26'hF, 1'b0, 1'b0, 0, 1'b0);

    do_insert(26'hD, 1'b1, 3, 1'b0, 0);
    wq.push_back(1);
    wq.push_back(3);
    do_flush(1'b0, 0);
    check("fl_wb_drained", wq.size(), 0);
    do_flush(1'b0, Entries + 1);
    do_lookup(26'hB, 1'b0, 1'b0, 0, 1'b0);

    // Flush and insert together: flush must win, no insert ack may appear.
    do_flush(1'b1, Entries + 1);

    // Reset in the middle of a writeback.
    do_insert(26'h20, 1'b1, 0, 1'b0, 0);
    do_insert(26'h21, 1'b0, 1, 1'b0, 0);
    do_insert(26'h22, 1'b0, 2, 1'b0, 0);
    do_insert(26'h23, 1'b0, 3, 1'b0, 0);
    wq.push_back(0);
    insert_req_i   = 1'b1;
    insert_tag_i   = 26'h30;
    insert_dirty_i = 1'b0;
    step();
    insert_req_i = 1'b0;
    @(negedge clk);
    check("rstwb_req", vc2mem_req_o, 1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstwb_outputs", {busy_o, vc2mem_req_o, vc2mem_kill_o, insert_ack_o}, 4'b0);
    check("rstwb_occ", occupancy_o, 0);
    step();
    do_lookup(26'h20, 1'b0, 1'b0, 0, 1'b0);

    check("sb_lk_left", lq.size(), 0);
    check("sb_ins_left", iq.size(), 0);
    check("sb_wb_left", wq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
